// File: rtl/board_row_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | board_row_arbiter: shares one board RAM between display row fetches and   |
// | single-cell game-logic accesses.                      Revision: 1.0       |
// +---------------------------------------------------------------------------+
module board_row_arbiter #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int CELL_W  = 16
) (
  input  logic                           Clk,
  input  logic                           reset,
  input  logic                           LD_Row,
  input  logic [7:0]                     rowNum,
  output logic [BOARD_W-1:0][CELL_W-1:0] Row,
  output logic                           rowReady,
  input  logic                           game_req,
  input  logic                           game_we,
  input  logic [3:0]                     game_x,
  input  logic [4:0]                     game_y,
  input  logic [CELL_W-1:0]              game_wdata,
  output logic                           game_gnt,
  output logic                           game_ack,
  output logic [CELL_W-1:0]              game_rdata,
  output logic                           game_err,
  output logic [7:0]                     mem_addr,
  output logic                           mem_we,
  output logic [CELL_W-1:0]              mem_wdata,
  input  logic [CELL_W-1:0]              mem_rdata
);

  localparam int             CW         = $clog2(BOARD_W + 1);
  localparam logic [CW-1:0]  c_col_last = CW'(BOARD_W);
  localparam logic [7:0]     c_w8       = 8'(BOARD_W);
  localparam logic [7:0]     c_h8       = 8'(BOARD_H);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISP_RD  = 2'd1,
    GAME_OP  = 2'd2,
    GAME_ACK = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic                             ld_q;
  logic                             armed_q;
  logic                             pend_q, pend_d;
  logic [7:0]                       pend_row_q, pend_row_d;
  logic [7:0]                       row_num_q, row_num_d;
  logic                             row_ok_q, row_ok_d;
  logic [CW-1:0]                    col_q, col_d;
  logic                             ready_q, ready_d;
  logic                             op_we_q, op_we_d;
  logic                             op_err_q, op_err_d;
  logic [BOARD_W-1:0][CELL_W-1:0]   row_q;

  logic                             w_ld_edge;
  logic                             w_capture;
  logic [7:0]                       w_start_row;
  logic [7:0]                       w_disp_addr;
  logic [7:0]                       w_game_addr;
  logic                             w_game_ok;

  // armed_q ignores an LD_Row level that was already high when reset released
  assign w_ld_edge   = LD_Row & ~ld_q & armed_q;
  assign w_disp_addr = row_num_q * c_w8 + 8'(col_q);
  assign w_game_addr = 8'(game_y) * c_w8 + 8'(game_x);
  assign w_game_ok   = (8'(game_x) < c_w8) && (8'(game_y) < c_h8);

  assign Row      = row_q;
  assign rowReady = ready_q;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ld_q       <= 1'b0;
      armed_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
      row_num_q  <= '0;
      row_ok_q   <= 1'b0;
      col_q      <= '0;
      ready_q    <= 1'b0;
      op_we_q    <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= LD_Row;
      armed_q    <= armed_q | ~LD_Row;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      row_num_q  <= row_num_d;
      row_ok_q   <= row_ok_d;
      col_q      <= col_d;
      ready_q    <= ready_d;
      op_we_q    <= op_we_d;
      op_err_q   <= op_err_d;
    end
  end

  // Cell k lands at the edge that ends the cycle with col_q == k+1
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < BOARD_W; k++) begin
        if (col_q == CW'(k + 1)) begin
          row_q[k] <= row_ok_q ? mem_rdata : '0;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_row_d  = pend_row_q;
    row_num_d   = row_num_q;
    row_ok_d    = row_ok_q;
    col_d       = col_q;
    ready_d     = ready_q;
    op_we_d     = op_we_q;
    op_err_d    = op_err_q;
    w_start_row = rowNum;
    w_capture   = 1'b0;
    game_gnt    = 1'b0;
    game_ack    = 1'b0;
    game_err    = 1'b0;
    game_rdata  = '0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    if (state_q != IDLE && w_ld_edge) begin
      pend_d     = 1'b1;
      pend_row_d = rowNum;
    end

    case (state_q)
      IDLE: begin
        if (w_ld_edge || pend_q) begin
          w_start_row = w_ld_edge ? rowNum : pend_row_q;
          row_num_d   = w_start_row;
          row_ok_d    = (w_start_row < c_h8);
          ready_d     = 1'b0;
          col_d       = '0;
          pend_d      = 1'b0;
          state_d     = DISP_RD;
        end else if (game_req) begin
          state_d = GAME_OP;
        end
      end
      DISP_RD: begin
        if (row_ok_q && col_q != c_col_last) begin
          mem_addr = w_disp_addr;
        end
        w_capture = (col_q != '0);
        if (col_q == c_col_last) begin
          ready_d = 1'b1;
          col_d   = '0;
          state_d = IDLE;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      GAME_OP: begin
        game_gnt = 1'b1;
        if (w_game_ok) begin
          mem_addr  = w_game_addr;
          mem_we    = game_we;
          mem_wdata = game_wdata;
        end
        op_we_d  = game_we;
        op_err_d = ~w_game_ok;
        state_d  = GAME_ACK;
      end
      GAME_ACK: begin
        game_ack = 1'b1;
        game_err = op_err_q;
        if (!op_we_q && !op_err_q) begin
          game_rdata = mem_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_board_row_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_board_row_arbiter: directed bench for board_row_arbiter with a         |
// | registered-read RAM model.                            Revision: 1.0       |
// +---------------------------------------------------------------------------+
module tb_board_row_arbiter;

  logic                 clk;
  logic                 reset;
  logic                 LD_Row;
  logic [7:0]           rowNum;
  logic [9:0][15:0]     Row;
  logic                 rowReady;
  logic                 game_req;
  logic                 game_we;
  logic [3:0]           game_x;
  logic [4:0]           game_y;
  logic [15:0]          game_wdata;
  logic                 game_gnt;
  logic                 game_ack;
  logic [15:0]          game_rdata;
  logic                 game_err;
  logic [7:0]           mem_addr;
  logic                 mem_we;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;

  logic [15:0]          ram    [0:255];
  logic [15:0]          shadow [0:255];
  int                   passed;
  int                   total;

  board_row_arbiter #(.BOARD_W(10), .BOARD_H(20), .CELL_W(16)) dut (
    .Clk        (clk),
    .reset      (reset),
    .LD_Row     (LD_Row),
    .rowNum     (rowNum),
    .Row        (Row),
    .rowReady   (rowReady),
    .game_req   (game_req),
    .game_we    (game_we),
    .game_x     (game_x),
    .game_y     (game_y),
    .game_wdata (game_wdata),
    .game_gnt   (game_gnt),
    .game_ack   (game_ack),
    .game_rdata (game_rdata),
    .game_err   (game_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    if (a >= 30 && a < 40) return 16'h0F00 + 16'(a - 30);
    return 16'h1000 + 16'(a);
  endfunction

  // Board RAM: one-cycle registered read, read-before-write
  initial begin
    for (int a = 0; a < 256; a++) ram[a] = init_val(a);
    forever begin
      @(posedge clk);
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [3:0]  x;
    logic [4:0]  y;
    logic [15:0] wdata;
    logic [7:0]  eaddr;
    logic        ewe;
    logic [15:0] erdata;
    logic        eerr;
  } gvec_t;

  gvec_t gv [0:8];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h required %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic do_game(input gvec_t v, input bit ld, input logic [7:0] ldrow);
    bit got;
    game_we    = v.we;
    game_x     = v.x;
    game_y     = v.y;
    game_wdata = v.wdata;
    game_req   = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (game_gnt) got = 1'b1;
    end
    chk("gnt_wait", 192'(got), 192'(1));
    if (got) begin
      if (!v.eerr) chk("op_addr", 192'(mem_addr), 192'(v.eaddr));
      chk("op_we", 192'(mem_we), 192'(v.ewe));
      if (ld) begin
        LD_Row = 1'b1;
        rowNum = ldrow;
      end
      @(negedge clk);
      chk("ack", 192'(game_ack), 192'(1));
      chk("gnt_one_cycle", 192'(game_gnt), 192'(0));
      chk("rdata", 192'(game_rdata), 192'(v.erdata));
      chk("err", 192'(game_err), 192'(v.eerr));
      if (v.we && v.x < 10 && v.y < 20) shadow[int'(v.y) * 10 + int'(v.x)] = v.wdata;
    end
    game_req = 1'b0;
    LD_Row   = 1'b0;
  endtask

  // Entered just after the fetch's start edge; optionally fires two edges mid-fetch
  task automatic fetch_body(input logic [7:0] r, input bit inj, input logic [7:0] ra,
                            input logic [7:0] rb);
    logic [9:0][15:0] er;
    logic [7:0]       ea;
    bit               ok;
    ok = (r < 20);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        LD_Row = 1'b0;
        chk("rdy_clear", 192'(rowReady), 192'(0));
      end
      if (k < 10) begin
        ea = ok ? 8'(int'(r) * 10 + k) : 8'd0;
        chk("disp_addr", 192'(mem_addr), 192'(ea));
        chk("disp_we", 192'(mem_we), 192'(0));
      end
      if (k == 10) chk("rdy_early", 192'(rowReady), 192'(0));
      if (inj) begin
        case (k)
          3: begin LD_Row = 1'b1; rowNum = ra; end
          5: LD_Row = 1'b0;
          7: begin LD_Row = 1'b1; rowNum = rb; end
          9: LD_Row = 1'b0;
          default: ;
        endcase
      end
    end
    @(negedge clk);
    chk("rdy_set", 192'(rowReady), 192'(1));
    for (int k = 0; k < 10; k++) er[k] = ok ? shadow[int'(r) * 10 + k] : 16'h0;
    chk("row_data", 192'(Row), 192'(er));
  endtask

  task automatic run_fetch(input logic [7:0] r);
    LD_Row = 1'b1;
    rowNum = r;
    @(posedge clk);
    fetch_body(r, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    int   gn, an;
    bit   seen;
    gvec_t gx;

    passed = 0;
    total  = 0;
    for (int a = 0; a < 256; a++) shadow[a] = init_val(a);

    //            we    x      y      wdata     eaddr  ewe   erdata    eerr
    gv[0] = '{1'b1, 4'd4,  5'd19, 16'h0ABC, 8'd194, 1'b1, 16'h0000, 1'b0};
    gv[1] = '{1'b0, 4'd4,  5'd19, 16'h0000, 8'd194, 1'b0, 16'h0ABC, 1'b0};
    gv[2] = '{1'b0, 4'd12, 5'd0,  16'h0000, 8'd0,   1'b0, 16'h0000, 1'b1};
    gv[3] = '{1'b0, 4'd0,  5'd20, 16'h0000, 8'd0,   1'b0, 16'h0000, 1'b1};
    gv[4] = '{1'b1, 4'd9,  5'd0,  16'h1234, 8'd9,   1'b1, 16'h0000, 1'b0};
    gv[5] = '{1'b0, 4'd9,  5'd0,  16'h0000, 8'd9,   1'b0, 16'h1234, 1'b0};
    gv[6] = '{1'b0, 4'd0,  5'd0,  16'h0000, 8'd0,   1'b0, 16'h1000, 1'b0};
    gv[7] = '{1'b1, 4'd15, 5'd31, 16'hDEAD, 8'd0,   1'b0, 16'h0000, 1'b1};
    gv[8] = '{1'b0, 4'd9,  5'd19, 16'h0000, 8'd199, 1'b0, 16'h10C7, 1'b1 & 1'b0};

    reset = 1'b0; LD_Row = 1'b1; rowNum = 8'd3;
    game_req = 1'b0; game_we = 1'b0; game_x = '0; game_y = '0; game_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_rowReady", 192'(rowReady), 192'(0));
    chk("rst_row", 192'(Row), 192'(0));
    chk("rst_game", 192'({game_gnt, game_ack, game_err, game_rdata}), 192'(0));
    chk("rst_mem", 192'({mem_we, mem_addr}), 192'(0));

    // LD_Row already high at release must not start a fetch
    reset = 1'b1;
    seen  = 1'b0;
    for (int n = 0; n < 13; n++) begin
      @(negedge clk);
      if (mem_addr != 8'd0 || rowReady) seen = 1'b1;
    end
    chk("held_high_no_fetch", 192'(seen), 192'(0));
    LD_Row = 1'b0;
    repeat (2) @(negedge clk);

    run_fetch(8'd3);

    for (int i = 0; i < 9; i++) begin
      do_game(gv[i], 1'b0, 8'd0);
      @(negedge clk);
    end

    run_fetch(8'd19);

    // Simultaneous LD_Row edge and game request: display wins
    LD_Row = 1'b1; rowNum = 8'd0;
    game_req = 1'b1; game_we = 1'b0; game_x = 4'd1; game_y = 5'd1;
    @(posedge clk);
    gn = -1; an = -1;
    for (int n = 0; n <= 20; n++) begin
      @(negedge clk);
      if (n == 0) LD_Row = 1'b0;
      if (game_gnt && gn < 0) gn = n;
      if (game_ack && an < 0) begin
        an = n;
        chk("collide_rdata", 192'(game_rdata), 192'(16'h100B));
        game_req = 1'b0;
      end
    end
    game_req = 1'b0;
    chk("collide_gnt_at", 192'(gn), 192'(12));
    chk("collide_ack_at", 192'(an), 192'(13));

    // Edges for rows 5 then 7 during a fetch: only row 7 is serviced next
    LD_Row = 1'b1; rowNum = 8'd2;
    @(posedge clk);
    fetch_body(8'd2, 1'b1, 8'd5, 8'd7);
    @(posedge clk);
    fetch_body(8'd7, 1'b0, 8'd0, 8'd0);

    run_fetch(8'd25);

    // Edge during a game op is held pending and fetched after the ack
    gx = '{1'b0, 4'd2, 5'd2, 16'h0000, 8'd22, 1'b0, 16'h1016, 1'b0};
    do_game(gx, 1'b1, 8'd4);
    @(posedge clk);
    @(posedge clk);
    fetch_body(8'd4, 1'b0, 8'd0, 8'd0);

    // Reset in the middle of a fetch
    LD_Row = 1'b1; rowNum = 8'd3;
    @(posedge clk);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0) LD_Row = 1'b0;
    end
    chk("pre_rst_addr", 192'(mem_addr), 192'(35));
    #1 reset = 1'b0;
    #1;
    chk("midrst_addr", 192'(mem_addr), 192'(0));
    chk("midrst_rdy", 192'(rowReady), 192'(0));
    chk("midrst_row", 192'(Row), 192'(0));
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (mem_addr != 8'd0 || rowReady) seen = 1'b1;
    end
    chk("post_rst_quiet", 192'(seen), 192'(0));
    run_fetch(8'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
